// File: rtl/seven_seg_scan_decoder.sv
// Receive side of a multiplexed 4-digit seven-segment bus: samples the
// active-low anode strobes and segment lines and rebuilds a 16-bit BCD frame.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   an[3:0]           anode strobes, active low, an[i]=0 selects digit i
//   seg[7:0]          segment lines, active low, seg[6:0]=g..a, seg[7]=dp
//   value[15:0]       last complete frame, value[4i+3:4i] = digit i
//   value_valid       frame held in value has not timed out
//   frame_done        one-cycle pulse when value is updated
//   bad_glyph         some digit of the last frame was undecodable
//   dp_seen, dp_pos   dp lit in last frame / highest digit with dp lit
//   sel_err           one-cycle pulse on an illegal anode pattern
module seven_seg_scan_decoder #(
    parameter int SETTLE  = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        frame_done,
    output logic        bad_glyph,
    output logic        dp_seen,
    output logic [1:0]  dp_pos,
    output logic        sel_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HELD
    } state_t;

    state_t      r_state, w_state_nx;
    logic [3:0]  r_an_q, r_an_d;
    logic [7:0]  r_seg_q;
    logic [7:0]  r_stab, w_stab_nx;
    logic [15:0] r_idle;

    logic [3:0]  r_mask, r_bad, r_dp;
    logic [15:0] r_nib;

    logic        r_pend;
    logic [15:0] r_pend_val;
    logic        r_pend_bad, r_pend_dps;
    logic [1:0]  r_pend_pos;

    logic [15:0] r_value;
    logic        r_valid, r_done, r_bad_out, r_dps_out, r_sel_err;
    logic [1:0]  r_pos_out;

    logic        w_legal, w_blank, w_illegal, w_changed, w_capture;
    logic [1:0]  w_idx;
    logic [3:0]  w_bit;
    logic [3:0]  w_glyph;
    logic        w_glyph_bad;
    logic [3:0]  w_mask_nx, w_bad_nx, w_dp_nx;
    logic [15:0] w_nib_nx;
    logic [1:0]  w_pos_nx;

    assign w_blank   = (r_an_q == 4'b1111);
    assign w_illegal = !w_legal && !w_blank;
    assign w_changed = (r_an_q != r_an_d);
    assign w_bit     = 4'b0001 << w_idx;

    always_comb begin
        w_legal = 1'b1;
        w_idx   = 2'd0;
        case (r_an_q)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_glyph_bad = 1'b0;
        w_glyph     = 4'hF;
        case (r_seg_q[6:0])
            7'b1000000: w_glyph = 4'd0;
            7'b1111001: w_glyph = 4'd1;
            7'b0100100: w_glyph = 4'd2;
            7'b0110000: w_glyph = 4'd3;
            7'b0011001: w_glyph = 4'd4;
            7'b0010010: w_glyph = 4'd5;
            7'b0000010: w_glyph = 4'd6;
            7'b1111000: w_glyph = 4'd7;
            7'b0000000: w_glyph = 4'd8;
            7'b0010000: w_glyph = 4'd9;
            default:    w_glyph_bad = 1'b1;
        endcase
    end

    // The stability count includes the current cycle, so with SETTLE=1 a
    // fresh selection is captured on the very first edge it is seen.
    always_comb begin
        w_state_nx = r_state;
        w_stab_nx  = r_stab;
        w_capture  = 1'b0;
        if (!w_legal) begin
            w_state_nx = S_IDLE;
            w_stab_nx  = 8'd0;
        end else if (r_state == S_HELD && !w_changed) begin
            w_state_nx = S_HELD;
        end else begin
            if (r_state == S_SETTLE && !w_changed)
                w_stab_nx = r_stab + 8'd1;
            else
                w_stab_nx = 8'd1;
            if (w_stab_nx == 8'(SETTLE)) begin
                w_capture  = 1'b1;
                w_state_nx = S_HELD;
            end else begin
                w_state_nx = S_SETTLE;
            end
        end
    end

    always_comb begin
        w_mask_nx = r_mask | w_bit;
        w_bad_nx  = w_glyph_bad ? (r_bad | w_bit) : (r_bad & ~w_bit);
        w_dp_nx   = !r_seg_q[7] ? (r_dp | w_bit) : (r_dp & ~w_bit);
        w_nib_nx  = r_nib;
        w_nib_nx[{w_idx, 2'b00} +: 4] = w_glyph;
        w_pos_nx  = 2'd0;
        if (w_dp_nx[1]) w_pos_nx = 2'd1;
        if (w_dp_nx[2]) w_pos_nx = 2'd2;
        if (w_dp_nx[3]) w_pos_nx = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an_q     <= 4'b1111;
            r_an_d     <= 4'b1111;
            r_seg_q    <= 8'hFF;
            r_state    <= S_IDLE;
            r_stab     <= 8'd0;
            r_idle     <= 16'd0;
            r_mask     <= 4'd0;
            r_bad      <= 4'd0;
            r_dp       <= 4'd0;
            r_nib      <= 16'd0;
            r_pend     <= 1'b0;
            r_pend_val <= 16'd0;
            r_pend_bad <= 1'b0;
            r_pend_dps <= 1'b0;
            r_pend_pos <= 2'd0;
            r_value    <= 16'd0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_bad_out  <= 1'b0;
            r_dps_out  <= 1'b0;
            r_pos_out  <= 2'd0;
            r_sel_err  <= 1'b0;
        end else begin
            r_an_q    <= an;
            r_an_d    <= r_an_q;
            r_seg_q   <= seg;
            r_state   <= w_state_nx;
            r_stab    <= w_stab_nx;
            r_sel_err <= w_illegal && w_changed;
            r_done    <= r_pend;
            r_pend    <= 1'b0;

            if (r_pend) begin
                r_value   <= r_pend_val;
                r_valid   <= 1'b1;
                r_bad_out <= r_pend_bad;
                r_dps_out <= r_pend_dps;
                r_pos_out <= r_pend_pos;
            end

            // A completed frame is staged for one edge so the next frame
            // can start accumulating immediately.
            if (w_capture) begin
                r_idle <= 16'd0;
                if (w_mask_nx == 4'b1111) begin
                    r_pend     <= 1'b1;
                    r_pend_val <= w_nib_nx;
                    r_pend_bad <= |w_bad_nx;
                    r_pend_dps <= |w_dp_nx;
                    r_pend_pos <= w_pos_nx;
                    r_mask     <= 4'd0;
                    r_bad      <= 4'd0;
                    r_dp       <= 4'd0;
                end else begin
                    r_mask <= w_mask_nx;
                    r_bad  <= w_bad_nx;
                    r_dp   <= w_dp_nx;
                end
                r_nib <= w_nib_nx;
            end else if (r_idle != 16'(TIMEOUT)) begin
                r_idle <= r_idle + 16'd1;
                if (r_idle == 16'(TIMEOUT - 1)) begin
                    r_valid <= 1'b0;
                    r_mask  <= 4'd0;
                    r_bad   <= 4'd0;
                    r_dp    <= 4'd0;
                end
            end
        end
    end

    assign value       = r_value;
    assign value_valid = r_valid;
    assign frame_done  = r_done;
    assign bad_glyph   = r_bad_out;
    assign dp_seen     = r_dps_out;
    assign dp_pos      = r_pos_out;
    assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: one instance with SETTLE=1,
// TIMEOUT=16 and one with SETTLE=3, TIMEOUT=1024 share the same pins.
module tb_seven_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [7:0]  seg;

    logic [15:0] v1, v3;
    logic        vv1, vv3, fd1, fd3, bg1, bg3, ds1, ds3, se1, se3;
    logic [1:0]  dp1, dp3;

    int checks = 0;
    int fails  = 0;
    int n_fd1  = 0;
    int n_fd3  = 0;
    int n_se1  = 0;

    seven_seg_scan_decoder #(.SETTLE(1), .TIMEOUT(16)) u1 (
        .clk(clk), .rst(rst), .an(an), .seg(seg),
        .value(v1), .value_valid(vv1), .frame_done(fd1),
        .bad_glyph(bg1), .dp_seen(ds1), .dp_pos(dp1), .sel_err(se1)
    );

    seven_seg_scan_decoder #(.SETTLE(3), .TIMEOUT(1024)) u3 (
        .clk(clk), .rst(rst), .an(an), .seg(seg),
        .value(v3), .value_valid(vv3), .frame_done(fd3),
        .bad_glyph(bg3), .dp_seen(ds3), .dp_pos(dp3), .sel_err(se3)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fd1) n_fd1 <= n_fd1 + 1;
        if (fd3) n_fd3 <= n_fd3 + 1;
        if (se1) n_se1 <= n_se1 + 1;
    end

    typedef struct {
        logic [3:0][3:0] d;
        logic [3:0]      dp;
        logic [15:0]     ev;
        logic            eb;
        logic            eds;
        logic [1:0]      epos;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Codes 10 and above produce undecodable glyphs.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h40;
            4'd1:    glyph = 7'h79;
            4'd2:    glyph = 7'h24;
            4'd3:    glyph = 7'h30;
            4'd4:    glyph = 7'h19;
            4'd5:    glyph = 7'h12;
            4'd6:    glyph = 7'h02;
            4'd7:    glyph = 7'h78;
            4'd8:    glyph = 7'h00;
            4'd9:    glyph = 7'h10;
            4'd10:   glyph = 7'h7F;
            default: glyph = 7'h2A;
        endcase
    endfunction

    task automatic drive(input int i, input logic [3:0] d, input logic dp);
        logic [3:0] b;
        b   = 4'b0001 << i;
        an  = ~b;
        seg = {~dp, glyph(d)};
    endtask

    task automatic blank();
        an  = 4'b1111;
        seg = 8'hFF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the last digit's pins are set; holds them for
    // 'hold' edges and measures edges until frame_done is seen.
    task automatic scan_last(input int which, input int hold,
                             input int exp_lat, input string name);
        int lat;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == hold) blank();
            if (lat == 0 && (which == 1 ? fd1 : fd3)) lat = k;
        end
        chk(name, lat, exp_lat);
    endtask

    initial begin
        int n0;

        vecs[0].d = {4'd1, 4'd2, 4'd3, 4'd4};
        vecs[0].dp = 4'b1000; vecs[0].ev = 16'h1234;
        vecs[0].eb = 1'b0; vecs[0].eds = 1'b1; vecs[0].epos = 2'd3;
        vecs[1].d = {4'd9, 4'd9, 4'd10, 4'd9};
        vecs[1].dp = 4'b0000; vecs[1].ev = 16'h99F9;
        vecs[1].eb = 1'b1; vecs[1].eds = 1'b0; vecs[1].epos = 2'd0;
        vecs[2].d = {4'd7, 4'd6, 4'd5, 4'd0};
        vecs[2].dp = 4'b0101; vecs[2].ev = 16'h7650;
        vecs[2].eb = 1'b0; vecs[2].eds = 1'b1; vecs[2].epos = 2'd2;
        vecs[3].d = {4'd11, 4'd8, 4'd8, 4'd8};
        vecs[3].dp = 4'b0011; vecs[3].ev = 16'hF888;
        vecs[3].eb = 1'b1; vecs[3].eds = 1'b1; vecs[3].epos = 2'd1;

        rst = 1'b1;
        blank();
        repeat (3) tick();
        chk("rst_value", v1, 16'h0);
        chk("rst_valid", vv1, 1'b0);
        chk("rst_done", fd1, 1'b0);
        chk("rst_bad", bg1, 1'b0);
        chk("rst_dps", {ds1, dp1}, 3'b000);
        chk("rst_selerr", se1, 1'b0);
        rst = 1'b0;
        repeat (2) tick();

        // SETTLE=1: one digit per clock, table-driven frames
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 3; i++) begin
                drive(i, vecs[v].d[i], vecs[v].dp[i]);
                tick();
            end
            drive(3, vecs[v].d[3], vecs[v].dp[3]);
            n0 = n_fd1;
            scan_last(1, 1, 3, $sformatf("v%0d_latency", v));
            chk($sformatf("v%0d_pulses", v), n_fd1 - n0, 1);
            chk($sformatf("v%0d_value", v), v1, vecs[v].ev);
            chk($sformatf("v%0d_valid", v), vv1, 1'b1);
            chk($sformatf("v%0d_bad", v), bg1, vecs[v].eb);
            chk($sformatf("v%0d_dpseen", v), ds1, vecs[v].eds);
            chk($sformatf("v%0d_dppos", v), dp1, vecs[v].epos);
        end
        chk("s3_no_frame_on_steps", n_fd3, 0);

        // SETTLE=3: 2-cycle holds capture nothing, 3-cycle holds do
        n0 = n_fd3;
        for (int i = 0; i < 4; i++) begin
            drive(i, 4'(i + 1), 1'b0);
            repeat (2) tick();
        end
        chk("s3_short_hold_frames", n_fd3 - n0, 0);
        chk("s3_short_hold_valid", vv3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(i, 4'(i + 5), 1'b0);
            repeat (3) tick();
        end
        drive(3, 4'd8, 1'b0);
        scan_last(3, 3, 5, "s3_latency");
        chk("s3_pulses", n_fd3 - n0, 1);
        chk("s3_value", v3, 16'h8765);
        chk("s3_valid", vv3, 1'b1);

        // illegal anode pattern mid-frame
        n0 = n_se1;
        drive(0, 4'd1, 1'b0); tick();
        drive(1, 4'd2, 1'b0); tick();
        an = 4'b1100; seg = 8'hFF;
        tick();
        chk("selerr_early", se1, 1'b0);
        drive(2, 4'd3, 1'b0);
        tick();
        chk("selerr_pulse", se1, 1'b1);
        drive(3, 4'd4, 1'b0);
        scan_last(1, 1, 3, "illegal_latency");
        chk("selerr_count", n_se1 - n0, 1);
        chk("illegal_value", v1, 16'h4321);

        // timeout after a complete frame
        drive(0, 4'd7, 1'b0); tick();
        drive(1, 4'd6, 1'b0); tick();
        drive(2, 4'd5, 1'b0); tick();
        drive(3, 4'd0, 1'b0);
        n0 = n_fd1;
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k == 1) blank();
            if (k == 17) chk("to_valid_before", vv1, 1'b1);
            if (k == 18) chk("to_valid_after", vv1, 1'b0);
        end
        chk("to_frame", n_fd1 - n0, 1);
        chk("to_value_held", v1, 16'h0567);

        // reset mid-frame discards captured digits
        drive(0, 4'd5, 1'b0); tick();
        drive(1, 4'd5, 1'b0); tick();
        blank(); tick();
        rst = 1'b1;
        tick();
        chk("mrst_value", v1, 16'h0);
        chk("mrst_valid", vv1, 1'b0);
        chk("mrst_flags", {fd1, bg1, ds1, dp1, se1}, 6'b0);
        tick();
        rst = 1'b0;
        tick();
        n0 = n_fd1;
        drive(2, 4'd8, 1'b0); tick();
        drive(3, 4'd8, 1'b0); tick();
        blank();
        repeat (4) tick();
        chk("mrst_no_stale_frame", n_fd1 - n0, 0);
        drive(0, 4'd8, 1'b0); tick();
        drive(1, 4'd8, 1'b0);
        scan_last(1, 1, 3, "mrst_latency");
        chk("mrst_value_new", v1, 16'h8888);
        chk("mrst_valid_new", vv1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
